seg_scan: RTL and testbench
===========================

# seg_scan

Display back-end for the calculator: captures decimal digits (0-9) produced by the decade counter and other arithmetic stages into a NUM_DIGITS-deep digit register and time-multiplexes them onto a common-anode seven-segment display. It sits directly downstream of the decade counter: the counter's 4-bit value feeds `digit_in`, and a strobe shifts it in. All outputs are registered and drive the board pins directly.

## Interface
- NUM_DIGITS, 4: number of display digits; 2..8.
- REFRESH_DIV, 100000: clock cycles each digit stays lit; ≥1.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- digit_in  in  4  BCD digit; codes 10-15 are "invalid".
- load  in  1  1-cycle strobe: shift `digit_in` into digit 0.
- clr  in  1  synchronous clear of all stored digits to 0.
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g.
- an  out  NUM_DIGITS  digit enables, active-low, one-cold.
- frame  out  1  1-cycle pulse when scan wraps from last digit to digit 0.

## Operation
- Digit store: NUM_DIGITS × 4-bit registers, d[0] = rightmost/least significant.
- `load`=1: d[i] <= d[i-1] for i ≥ 1, d[0] <= digit_in; old d[NUM_DIGITS-1] is discarded.
- `clr`=1: all d[i] <= 0. `clr` and `load` in the same cycle: `clr` wins and `digit_in` is dropped.
- Prescaler `pre` counts 0..REFRESH_DIV-1 and then wraps to 0. Scan index `idx` counts 0..NUM_DIGITS-1 and advances by 1 in the cycle `pre`==REFRESH_DIV-1, wrapping NUM_DIGITS-1 → 0.
- Decode (active-low patterns for seg[6:0]):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - invalid (10-15)=0111111 (dash)
  - blank=1111111
- Output registers: each cycle, `an` <= one-cold with bit `idx` low; `seg` <= decode(d[idx]).
- `frame` <= 1 for exactly one cycle when `idx` wraps to 0.
- Reset (rst_n=0 at an edge):
  - d[*]=0, pre=0, idx=0.
  - an=all ones (dark), seg=1111111, frame=0.
  - Reset overrides `load`/`clr`. Reset asserted mid-scan restarts at digit 0 with a full REFRESH_DIV dwell.

## Timing
- First edge after rst_n returns high: an=…1110, seg=decode(d[0])=1000000.
- `idx` changes one edge after the terminal count of `pre`. `an`/`seg` follow one edge later, so every digit is lit for exactly REFRESH_DIV cycles.
- Load latency: `load` at edge N updates d at edge N. If digit 0 is being scanned, `seg` shows the new value after edge N+1.
- REFRESH_DIV=1: `idx` advances every cycle; full frame = NUM_DIGITS cycles. `frame` period = NUM_DIGITS×REFRESH_DIV cycles.
- `an` never has more than one bit low. On a digit change, `an` and `seg` switch on the same edge.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. Any digit d[i] with i ≥ 1 that is 0 and has all higher digits also 0 decodes to blank (1111111); `an` still scans normally. d[0] is never blanked. Invalid codes count as nonzero.
- `SEG_LZB_EN` undefined: all digits decode literally; zeros show as "0".

## Test plan
- Reset/idle, REFRESH_DIV=4, NUM_DIGITS=4: release reset → an cycles 1110, 1101, 1011, 0111, 4 cycles each. seg=1000000 throughout. frame pulses every 16 cycles.
- Load sequence: load 1, 2, 3, 4 on consecutive cycles → d[3..0]=1,2,3,4. seg shows 0011001 while an=1110 and 1111001 while an=0111.
- Overflow and invalid code: after loading 1,2,3,4, load 9 then 12 → d[3..0]=3,4,9,12. Digit 0 shows 0111111, digit 3 shows 0110000.
- clr and load in the same cycle with digit_in=7 → all digits 0 and no 7 stored. Reset asserted mid-frame (idx=2) → next edge gives an=1111, then an=1110 for 4 cycles.
- `SEG_LZB_EN`: load 0, 0, 5 after clr → d[3..0]=0,0,0,5. Digits 3-1 show 1111111 and digit 0 shows 0010010. Without the macro, digits 3-1 show 1000000.
- REFRESH_DIV=1, NUM_DIGITS=2: an alternates 10, 01 every cycle and frame pulses every 2 cycles.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: BCD digit store time-multiplexed onto an active-low seven-segment display.
// Latency: load updates the store at the strobe edge; seg/an are registered one edge after idx.
// Backpressure: none; load/clr are single-cycle strobes, accepted every cycle. Option: SEG_LZB_EN.
module seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            digit_in,
    input  logic                  load,
    input  logic                  clr,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [3:0]            d [NUM_DIGITS];
    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic                  pre_tc;
    logic                  idx_wrap;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;

    // BCD to active-low segment pattern (seg[6]=g .. seg[0]=a); 10-15 show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    assign pre_tc   = (pre == PRE_LAST);
    assign idx_wrap = pre_tc && (idx == IDX_LAST);

    // Digit store: shift-in on load; clear beats load, reset beats both
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) d[i] <= 4'd0;
        end else if (load) begin
            d[0] <= digit_in;
            for (int i = 1; i < NUM_DIGITS; i++) d[i] <= d[i-1];
        end
    end

    // Dwell prescaler and scan index; idx steps on the prescaler terminal count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= pre_tc ? '0 : pre + 1'b1;
            if (pre_tc) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef SEG_LZB_EN
    logic upper_zero;

    // Leading-zero mask: digit i blanks when it and every digit above it is zero; d[0] never blanks
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (d[i] == 4'd0);
            blank[i]   = upper_zero;
        end
    end
`else
    // Literal display: nothing is ever blanked
    always_comb begin
        blank = '0;
    end
`endif

    // Next output values for the digit currently selected by idx
    always_comb begin
        an_nxt      = '1;
        an_nxt[idx] = 1'b0;
        seg_nxt     = blank[idx] ? SEG_BLANK : decode(d[idx]);
    end

    // Pin registers: display dark in reset, frame marks the idx wrap to digit 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an    <= '1;
            seg   <= SEG_BLANK;
            frame <= 1'b0;
        end else begin
            an    <= an_nxt;
            seg   <= seg_nxt;
            frame <= idx_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan (4 digits / dwell 4, plus 2 digits / dwell 1).
// Stimulus pushes per-cycle expected pin values into a queue; a negedge monitor pops and compares.
// Expected segment patterns are hand-entered constants; leading-zero cases follow SEG_LZB_EN.
module tb_seg_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef SEG_LZB_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    typedef struct {
        bit         chk;
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
        logic [1:0] an2;
        logic [6:0] seg2;
        logic       frame2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic       clr;
    logic [3:0] digit_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;
    logic [6:0] seg2;
    logic [1:0] an2;
    logic       frame2;

    exp_t       q[$];
    logic [6:0] es [4];
    int         t;
    int         n_chk;
    int         n_fail;

    always #5 clk = ~clk;

    seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit_in (digit_in),
        .load     (load),
        .clr      (clr),
        .seg      (seg),
        .an       (an),
        .frame    (frame)
    );

    seg_scan #(.NUM_DIGITS(2), .REFRESH_DIV(1)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .digit_in (4'd0),
        .load     (1'b0),
        .clr      (1'b0),
        .seg      (seg2),
        .an       (an2),
        .frame    (frame2)
    );

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (time %0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: record what the pins must show after it, then move off the edge
    task automatic tick(input bit chk, input bit in_rst);
        exp_t e;
        int   k;
        @(posedge clk);
        e.chk = chk;
        if (in_rst) begin
            t        = 0;
            e.an     = 4'hF;
            e.seg    = SB;
            e.frame  = 1'b0;
            e.an2    = 2'b11;
            e.seg2   = SB;
            e.frame2 = 1'b0;
        end else begin
            t++;
            k        = ((t - 1) / 4) % 4;
            e.an     = 4'hF;
            e.an[k]  = 1'b0;
            e.seg    = es[k];
            e.frame  = ((t % 16) == 0);
            e.an2    = ((t % 2) == 1) ? 2'b10 : 2'b01;
            e.seg2   = ((t % 2) == 1) ? S0 : LZ;
            e.frame2 = ((t % 2) == 0);
        end
        q.push_back(e);
        #1;
    endtask

    // Monitor: pins are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                cmp("an",     8'(an),     8'(e.an));
                cmp("seg",    8'(seg),    8'(e.seg));
                cmp("frame",  8'(frame),  8'(e.frame));
                cmp("an2",    8'(an2),    8'(e.an2));
                cmp("seg2",   8'(seg2),   8'(e.seg2));
                cmp("frame2", 8'(frame2), 8'(e.frame2));
            end
        end
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        t        = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        digit_in = 4'd0;
        es       = '{S0, LZ, LZ, LZ};

        // Reset and idle scan over two and a half frames
        tick(1, 1);
        tick(1, 1);
        rst_n = 1'b1;
        repeat (40) tick(1, 0);

        // Load 1,2,3,4 back to back -> d[3..0] = 1,2,3,4
        load = 1'b1;
        digit_in = 4'd1; tick(0, 0);
        digit_in = 4'd2; tick(0, 0);
        digit_in = 4'd3; tick(0, 0);
        digit_in = 4'd4; tick(0, 0);
        load = 1'b0; digit_in = 4'd0;
        tick(0, 0);
        es = '{S4, S3, S2, S1};
        repeat (20) tick(1, 0);

        // Overflow plus invalid code -> d[3..0] = 3,4,9,12
        load = 1'b1;
        digit_in = 4'd9;  tick(0, 0);
        digit_in = 4'd12; tick(0, 0);
        load = 1'b0; digit_in = 4'd0;
        tick(0, 0);
        es = '{SD, S9, S4, S3};
        repeat (20) tick(1, 0);

        // clr and load together: clear wins, the 7 is dropped
        clr = 1'b1; load = 1'b1; digit_in = 4'd7;
        tick(0, 0);
        clr = 1'b0; load = 1'b0; digit_in = 4'd0;
        tick(0, 0);
        es = '{S0, LZ, LZ, LZ};
        repeat (20) tick(1, 0);

        // Reset while digit 2 is lit: dark for one edge, then full dwell on digit 0
        while ((t % 16) != 9) tick(1, 0);
        rst_n = 1'b0;
        tick(1, 1);
        rst_n = 1'b1;
        repeat (20) tick(1, 0);

        // clr then load 0,0,5 -> d[3..0] = 0,0,0,5
        clr = 1'b1; tick(0, 0); clr = 1'b0;
        load = 1'b1;
        digit_in = 4'd0; tick(0, 0);
        digit_in = 4'd0; tick(0, 0);
        digit_in = 4'd5; tick(0, 0);
        load = 1'b0; digit_in = 4'd0;
        tick(0, 0);
        es = '{S5, LZ, LZ, LZ};
        repeat (20) tick(1, 0);

        // Load 0 -> d[3..0] = 0,0,5,0: the least significant zero is always shown
        load = 1'b1; digit_in = 4'd0; tick(0, 0);
        load = 1'b0;
        tick(0, 0);
        es = '{S0, S5, LZ, LZ};
        repeat (20) tick(1, 0);

        // clr then 12,0,0 -> d[3..0] = 0,12,0,0: an invalid code stops zero blanking below it
        clr = 1'b1; tick(0, 0); clr = 1'b0;
        load = 1'b1;
        digit_in = 4'd12; tick(0, 0);
        digit_in = 4'd0;  tick(0, 0);
        digit_in = 4'd0;  tick(0, 0);
        load = 1'b0;
        tick(0, 0);
        es = '{S0, S0, SD, LZ};
        repeat (20) tick(1, 0);

        // Let the monitor drain the last expectation, bounded
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
